// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with 32-byte lines held in flops.
// Misses go through a line-granular backing-memory handshake; hits respond one cycle later.
module dcache_responder #(
    parameter int unsigned SET_BITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   d_cache_addr,
    input  logic [3:0]    d_cache_rmask,
    input  logic [3:0]    d_cache_wmask,
    input  logic [31:0]   d_cache_wdata,
    output logic [31:0]   d_cache_rdata,
    output logic          d_cache_resp,
    output logic [31:0]   bmem_addr,
    output logic          bmem_read,
    output logic          bmem_write,
    output logic [255:0]  bmem_wdata,
    input  logic [255:0]  bmem_rdata,
    input  logic          bmem_resp
);

    localparam int unsigned Sets = 1 << SET_BITS;
    localparam int unsigned TagW = 27 - SET_BITS;

    typedef enum logic [1:0] {StIdle, StResp, StWb, StFill} state_e;

    state_e          state_q;
    logic            valid_q [Sets];
    logic            dirty_q [Sets];
    logic [TagW-1:0] tag_q   [Sets];
    logic [255:0]    data_q  [Sets];

    logic [31:0]  rdata_q;
    logic         resp_q;
    logic [31:0]  baddr_q;
    logic         bread_q;
    logic         bwrite_q;
    logic [255:0] bwdata_q;

    logic [SET_BITS-1:0] idx;
    logic [TagW-1:0]     tag;
    logic [2:0]          word;
    logic                req;
    logic                hit;
    logic [31:0]         sel_word;
    logic [255:0]        line_merged;
    logic                unused_addr;

    assign idx         = d_cache_addr[4+SET_BITS:5];
    assign tag         = d_cache_addr[31:5+SET_BITS];
    assign word        = d_cache_addr[4:2];
    assign req         = (|d_cache_rmask) || (|d_cache_wmask);
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);
    assign sel_word    = data_q[idx][32*int'(word) +: 32];
    assign unused_addr = ^d_cache_addr[1:0];

    // Byte-lane merge of the store into the resident line; unmasked lanes keep old bytes.
    always_comb begin
        line_merged = data_q[idx];
        for (int b = 0; b < 4; b++) begin
            if (d_cache_wmask[b]) begin
                line_merged[32*int'(word) + 8*b +: 8] = d_cache_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
            baddr_q  <= '0;
            bread_q  <= 1'b0;
            bwrite_q <= 1'b0;
            bwdata_q <= '0;
            for (int i = 0; i < Sets; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        if (hit) begin
                            if (|d_cache_rmask) begin
                                rdata_q <= sel_word;
                            end else begin
                                data_q[idx]  <= line_merged;
                                dirty_q[idx] <= 1'b1;
                            end
                            resp_q  <= 1'b1;
                            state_q <= StResp;
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            bwrite_q <= 1'b1;
                            baddr_q  <= {tag_q[idx], idx, 5'b0};
                            bwdata_q <= data_q[idx];
                            state_q  <= StWb;
                        end else begin
                            bread_q <= 1'b1;
                            baddr_q <= {d_cache_addr[31:5], 5'b0};
                            state_q <= StFill;
                        end
                    end
                end
                StResp: begin
                    resp_q  <= 1'b0;
                    state_q <= StIdle;
                end
                StWb: begin
                    if (bmem_resp) begin
                        dirty_q[idx] <= 1'b0;
                        bwrite_q     <= 1'b0;
                        bread_q      <= 1'b1;
                        baddr_q      <= {d_cache_addr[31:5], 5'b0};
                        state_q      <= StFill;
                    end
                end
                StFill: begin
                    // Install and return to idle; the held request then re-looks-up as a hit.
                    if (bmem_resp) begin
                        data_q[idx]  <= bmem_rdata;
                        tag_q[idx]   <= tag;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        bread_q      <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign d_cache_rdata = rdata_q;
    assign d_cache_resp  = resp_q;
    assign bmem_addr     = baddr_q;
    assign bmem_read     = bread_q;
    assign bmem_write    = bwrite_q;
    assign bmem_wdata    = bwdata_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a backing-memory model plus a response scoreboard
// whose monitor pops expected read data whenever the cache pulses d_cache_resp.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  d_cache_addr;
    logic [3:0]   d_cache_rmask;
    logic [3:0]   d_cache_wmask;
    logic [31:0]  d_cache_wdata;
    logic [31:0]  d_cache_rdata;
    logic         d_cache_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [255:0] bmem_wdata;
    logic [255:0] bmem_rdata;
    logic         bmem_resp;

    dcache_responder #(.SET_BITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_cache_addr (d_cache_addr),
        .d_cache_rmask(d_cache_rmask),
        .d_cache_wmask(d_cache_wmask),
        .d_cache_wdata(d_cache_wdata),
        .d_cache_rdata(d_cache_rdata),
        .d_cache_resp (d_cache_resp),
        .bmem_addr    (bmem_addr),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {bit chk; logic [31:0] data;} exp_t;
    typedef struct {bit wr; logic [31:0] addr; logic [255:0] data;} xfer_t;

    exp_t         exp_q [$];
    exp_t         mon_e;
    xfer_t        log_q [$];
    logic [255:0] mem [logic [26:0]];
    int           mode;           // 0: normal memory, 1: never respond, 2: random resp pulses
    int           bmem_resp_cyc = 0;

    function void check32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    function void check256(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    function automatic logic [255:0] line_of(logic [31:0] base, logic [31:0] w1);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        l[63:32] = w1;
        return l;
    endfunction

    // Backing memory: answers each held transfer on its third cycle.
    initial begin
        logic [31:0]  first_addr;
        logic [255:0] first_wdata;
        int           cnt;
        bmem_resp   = 1'b0;
        bmem_rdata  = '0;
        cnt         = 0;
        first_addr  = '0;
        first_wdata = '0;
        forever begin
            @(negedge clk);
            bmem_resp = 1'b0;
            if (mode == 2) begin
                bmem_resp = 1'($urandom_range(0, 1));
            end else if (!rst && (bmem_read || bmem_write)) begin
                check32("bmem_rd_wr_exclusive", 32'(bmem_read & bmem_write), 0);
                if (cnt == 0) begin
                    first_addr  = bmem_addr;
                    first_wdata = bmem_wdata;
                end
                cnt++;
                if (cnt == 3 && mode == 0) begin
                    check32("bmem_addr_stable", bmem_addr, first_addr);
                    if (bmem_write) begin
                        check256("bmem_wdata_stable", bmem_wdata, first_wdata);
                        mem[bmem_addr[31:5]] = bmem_wdata;
                        log_q.push_back('{1'b1, bmem_addr, bmem_wdata});
                    end else begin
                        bmem_rdata = mem.exists(bmem_addr[31:5]) ? mem[bmem_addr[31:5]] : '0;
                        log_q.push_back('{1'b0, bmem_addr, bmem_rdata});
                    end
                    bmem_resp     = 1'b1;
                    bmem_resp_cyc = cyc;
                    cnt           = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && d_cache_resp) begin
            if (exp_q.size() == 0) begin
                check32("unexpected_resp", 32'(d_cache_resp), 0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) check32("resp_rdata", d_cache_rdata, mon_e.data);
            end
        end
    end

    task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, input bit chk, input logic [31:0] exp,
                       output int lat);
        int c0;
        int n;
        exp_q.push_back('{chk, exp});
        @(negedge clk);
        d_cache_addr  = a;
        d_cache_rmask = rm;
        d_cache_wmask = wm;
        d_cache_wdata = wd;
        c0 = cyc;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_cache_resp && n < 200);
        if (!d_cache_resp) check32("resp_timeout", 32'(d_cache_resp), 1);
        lat = cyc - c0;
        d_cache_rmask = '0;
        d_cache_wmask = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           wait_n;
        logic         idle_act;
        logic [255:0] line100;
        logic [255:0] line300;
        line100 = line_of(32'h1111_0000, 32'hDEAD_BEEF);
        line300 = line_of(32'h3000_0000, 32'h3000_0001);
        mem[27'h8]  = line100;
        mem[27'h18] = line300;
        mode = 0;
        rst  = 1'b1;
        d_cache_addr  = '0;
        d_cache_rmask = '0;
        d_cache_wmask = '0;
        d_cache_wdata = '0;
        repeat (3) @(negedge clk);
        check32("rst_resp", 32'(d_cache_resp), 0);
        check32("rst_rdata", d_cache_rdata, 0);
        check32("rst_bmem_read", 32'(bmem_read), 0);
        check32("rst_bmem_write", 32'(bmem_write), 0);
        check32("rst_bmem_addr", bmem_addr, 0);
        check256("rst_bmem_wdata", bmem_wdata, '0);
        rst = 1'b0;

        // Cold read miss.
        log_q.delete();
        req(32'h0000_0104, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, lat);
        check32("cold_lat_after_bmem", cyc - bmem_resp_cyc, 2);
        check32("cold_xfer_count", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            check32("cold_xfer_is_read", 32'(log_q[0].wr), 0);
            check32("cold_fill_addr", log_q[0].addr, 32'h0000_0100);
        end

        // Read hit.
        log_q.delete();
        req(32'h0000_0104, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, lat);
        check32("hit_latency", lat, 1);
        check32("hit_no_bmem", log_q.size(), 0);

        // Byte write hit, then read back.
        req(32'h0000_0104, 4'h0, 4'b0010, 32'h0000_AB00, 1'b0, 32'h0, lat);
        check32("write_hit_latency", lat, 1);
        req(32'h0000_0104, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_ABEF, lat);
        check32("readback_latency", lat, 1);

        // Dirty eviction by a conflicting read.
        log_q.delete();
        req(32'h0000_0304, 4'hF, 4'h0, 32'h0, 1'b1, 32'h3000_0001, lat);
        check32("evict_lat_after_bmem", cyc - bmem_resp_cyc, 2);
        check32("evict_xfer_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check32("evict_first_is_write", 32'(log_q[0].wr), 1);
            check32("evict_wb_addr", log_q[0].addr, 32'h0000_0100);
            check256("evict_wb_data", log_q[0].data, line_of(32'h1111_0000, 32'hDEAD_ABEF));
            check32("evict_second_is_read", 32'(log_q[1].wr), 0);
            check32("evict_fill_addr", log_q[1].addr, 32'h0000_0300);
        end

        // Refilled line is clean: evicting it needs no writeback.
        log_q.delete();
        req(32'h0000_0104, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_ABEF, lat);
        check32("clean_victim_xfers", log_q.size(), 1);
        if (log_q.size() >= 1) check32("clean_victim_read_only", 32'(log_q[0].wr), 0);

        // Reset in the middle of a fill.
        mode = 1;
        @(negedge clk);
        d_cache_addr  = 32'h0000_0304;
        d_cache_rmask = 4'hF;
        wait_n = 0;
        while (!bmem_read && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check32("midfill_read_up", 32'(bmem_read), 1);
        check32("midfill_addr", bmem_addr, 32'h0000_0300);
        rst = 1'b1;
        d_cache_rmask = '0;
        @(negedge clk);
        check32("midfill_rst_read", 32'(bmem_read), 0);
        check32("midfill_rst_write", 32'(bmem_write), 0);
        check32("midfill_rst_resp", 32'(d_cache_resp), 0);
        rst  = 1'b0;
        mode = 0;

        log_q.delete();
        req(32'h0000_0104, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_ABEF, lat);
        check32("post_rst_miss_xfers", log_q.size(), 1);
        if (log_q.size() >= 1) check32("post_rst_fill_addr", log_q[0].addr, 32'h0000_0100);

        // Idle with stray bmem_resp pulses.
        mode = 2;
        idle_act = 1'b0;
        repeat (20) begin
            @(negedge clk);
            idle_act = idle_act | bmem_read | bmem_write;
        end
        check32("idle_bmem_quiet", 32'(idle_act), 0);
        mode = 0;
        log_q.delete();
        req(32'h0000_0104, 4'hF, 4'h0, 32'h0, 1'b1, 32'hDEAD_ABEF, lat);
        check32("idle_then_hit_latency", lat, 1);
        check32("idle_then_hit_no_bmem", log_q.size(), 0);

        repeat (3) @(negedge clk);
        check32("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
Responder end of the data-side memory request interface driven by the load/store memory arbiter.
- Direct-mapped, write-back, write-allocate data cache holding 32-byte lines in flop arrays.
- Accepts one word-aligned request with a byte mask, returns a single-cycle response pulse.
- Misses are serviced through a 256-bit line-granular backing-memory handshake.

Parameters:
SET_BITS, 4, log2 of number of sets; legal values 1..6. Address split: offset [4:0], index [4+SET_BITS:5], tag [31:5+SET_BITS].

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
d_cache_addr  input  32  request address; [1:0] ignored (word aligned).
d_cache_rmask  input  4  read byte mask; nonzero means read request.
d_cache_wmask  input  4  write byte mask; nonzero means write request.
d_cache_wdata  input  32  write data, already lane-aligned to wmask.
d_cache_rdata  output  32  full aligned word; valid only while d_cache_resp=1.
d_cache_resp  output  1  one-cycle completion pulse.
bmem_addr  output  32  line address; [4:0]=0.
bmem_read  output  1  line fill request; held until bmem_resp.
bmem_write  output  1  line writeback request; held until bmem_resp.
bmem_wdata  output  256  victim line data.
bmem_rdata  input  256  fill line data; sampled when bmem_resp=1 during fill.
bmem_resp  input  1  backing-memory completion pulse.

Behaviour:
Requester contract:
- Request is pending while rmask or wmask is nonzero. The two are never both nonzero.
- addr, masks and wdata are held stable from first assertion through the d_cache_resp cycle.
- Requester drops masks for at least one cycle after resp.
- Requests are never withdrawn, including after a mispredict; every request is completed.

Storage: per set valid, dirty, tag, 256-bit data. Word select is addr[4:2].

Reset:
- valid and dirty cleared everywhere; state=IDLE.
- d_cache_resp=0, d_cache_rdata=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0.
- Reset mid-fill or mid-writeback abandons the transfer: bmem_read and bmem_write are low the cycle after reset. Tag/data contents are don't-care once valid=0.

State machine IDLE, RESP, WB, FILL:
- IDLE, no request -> IDLE.
- IDLE, request and hit (valid && tag match):
  - Read: latch the selected word into d_cache_rdata.
  - Write: merge wdata into the line per wmask byte lanes, set dirty.
  - -> RESP.
- IDLE, request and miss with victim clean or invalid -> FILL.
- IDLE, request and miss with victim valid and dirty -> WB.
- RESP: d_cache_resp=1 for exactly this cycle; no lookup is performed -> IDLE.
- WB:
  - bmem_write=1, bmem_addr={victim tag, index, 5'b0}, bmem_wdata=victim line, all held stable.
  - On bmem_resp: clear dirty -> FILL.
- FILL:
  - bmem_read=1, bmem_addr={addr[31:5], 5'b0}, held stable.
  - On bmem_resp: install bmem_rdata, set tag, valid=1, dirty=0 -> IDLE. The request is re-looked-up and hits.

Latency:
- Hit: resp in cycle N+1 after the request is first seen in IDLE at cycle N.
- Clean miss: resp two cycles after the bmem_resp of the fill.
- Dirty miss: adds the writeback handshake ahead of the fill.

Other rules:
- bmem_resp outside WB or FILL is ignored.
- bmem_read and bmem_write are never high in the same cycle.
- rmask partial reads still return the full word; the requester extracts bytes.
- A wmask lane of 0 leaves that byte unchanged.
- No hit-under-miss and no second outstanding request.

Test Plan:
- Cold read: rmask=1111 at addr 0x00000104; bmem_rdata word1=0xDEADBEEF -> bmem_read with bmem_addr=0x00000100 until bmem_resp, then resp with rdata=0xDEADBEEF two cycles after bmem_resp. bmem_write never asserted.
- Read hit: repeat the same read after the masks drop for one cycle -> resp exactly one cycle after the request, rdata=0xDEADBEEF, no bmem activity.
- Byte write hit: wmask=0010, wdata=0x0000AB00 at 0x00000104, then lw at 0x00000104 -> rdata=0xDEADABEF; the set is dirty.
- Dirty eviction (SET_BITS=4): read at 0x00000304, which maps to the same set as 0x100 -> bmem_write at bmem_addr=0x00000100 with word1=0xDEADABEF, then bmem_read at 0x00000300, then resp. The new line is clean.
- Reset mid-fill: assert rst while bmem_read=1 -> next cycle bmem_read=0 and resp=0; a later read of 0x00000104 misses again.
- Idle: masks 0 for 20 cycles with random bmem_resp pulses -> no resp, no bmem_read/bmem_write, contents unchanged.
